data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, >=4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, idle cycles inserted between request acceptance and response (0..15).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_srst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_reqValid  input  1  initiator presents a request.
REQ-006 SHALL have port o_reqReady  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port i_reqWrite  input  1  1 = store, 0 = load.
REQ-008 SHALL have port i_reqAddress  input  32  byte address.
REQ-009 SHALL have port i_reqWriteData  input  32  store data.
REQ-010 SHALL have port i_reqByteEn  input  4  store byte enables; bit n gates byte lane n.
REQ-011 SHALL have port o_rspValid  output  1  response available.
REQ-012 SHALL have port i_rspReady  input  1  initiator accepts the response.
REQ-013 SHALL have port o_rspReadData  output  32  load data; 0 for stores and errored requests.
REQ-014 SHALL have port o_rspError  output  1  request was rejected (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 o_reqReady SHALL be 1 only in IDLE; a request is accepted on an edge where i_reqValid && o_reqReady.
REQ-017 On acceptance, SHALL register write flag, word index, write data, byte enables and error status; inputs ignored thereafter.
REQ-018 IDLE -> WAIT on acceptance when WAIT_CYCLES > 0, loading a down-counter with WAIT_CYCLES; IDLE -> RESP directly when WAIT_CYCLES == 0.
REQ-019 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where counter reaches 1 (exactly WAIT_CYCLES cycles in WAIT).
REQ-020 Stores SHALL commit on the WAIT/IDLE -> RESP edge, updating only enabled byte lanes; i_reqByteEn == 0 commits nothing but still responds.
REQ-021 Loads SHALL sample the addressed word on the WAIT/IDLE -> RESP edge, so a load always returns data from every previously responded store.
REQ-022 In RESP, o_rspValid SHALL be 1 and o_rspReadData/o_rspError SHALL stay stable until i_rspReady is high on an edge, then -> IDLE.
REQ-023 o_reqReady SHALL be 0 in the cycle the response completes; minimum transaction spacing is WAIT_CYCLES + 2 cycles.
REQ-024 Errored requests SHALL never modify memory.

Reset
REQ-025 While i_srst is high at an edge: state -> IDLE, counter -> 0, o_rspValid -> 0, o_rspReadData -> 0, o_rspError -> 0; o_reqReady is 1 from the first cycle after reset.
REQ-026 Reset mid-transaction SHALL discard it with no response; a store already committed remains; memory contents are never cleared by reset.
REQ-027 i_srst SHALL take priority over a simultaneous request or response handshake.

Configuration
REQ-028 Macro DATA_MEM_RESPONDER_ERROR_CHECK_EN defined: i_reqAddress[1:0] != 0 or i_reqAddress >= 4*DEPTH_WORDS sets o_rspError = 1 with o_rspReadData = 0 and no store.
REQ-029 Macro undefined: o_rspError tied 0, i_reqAddress[1:0] ignored, word index = i_reqAddress[$clog2(DEPTH_WORDS)+1:2] (modulo wrap-around).

Verification
REQ-030 WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, byteEn 0xF -> o_rspValid rises exactly 3 cycles after acceptance, error 0; subsequent load 0x10 -> 0xDEADBEEF.
REQ-031 Store 0x000000AA to 0x10 with byteEn 0x1 over 0xDEADBEEF -> load 0x10 returns 0xDEADBEAA.
REQ-032 Load response held with i_rspReady low 5 cycles -> o_rspValid, data stable all 5 cycles, o_reqReady 0; completes on first i_rspReady high.
REQ-033 ERROR_CHECK_EN: store to 0x12 and to 0x400 (DEPTH_WORDS=256) -> o_rspError 1, memory unchanged; without macro, load 0x400 returns word 0 contents.
REQ-034 i_srst asserted in WAIT of a load -> no o_rspValid, o_reqReady 1 next cycle; WAIT_CYCLES=0 store -> response one cycle after acceptance.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and data_mem_responder.
// Member names carry the responder's view: i_* are driven by the initiator,
// o_* are driven by the responder.
//   master : initiator side (drives requests, accepts responses)
//   slave  : responder side (accepts requests, drives responses)
interface data_mem_responder_if;
    logic        i_reqValid;
    logic        o_reqReady;
    logic        i_reqWrite;
    logic [31:0] i_reqAddress;
    logic [31:0] i_reqWriteData;
    logic [3:0]  i_reqByteEn;
    logic        o_rspValid;
    logic        i_rspReady;
    logic [31:0] o_rspReadData;
    logic        o_rspError;

    modport master (
        output i_reqValid,
        output i_reqWrite,
        output i_reqAddress,
        output i_reqWriteData,
        output i_reqByteEn,
        output i_rspReady,
        input  o_reqReady,
        input  o_rspValid,
        input  o_rspReadData,
        input  o_rspError
    );

    modport slave (
        input  i_reqValid,
        input  i_reqWrite,
        input  i_reqAddress,
        input  i_reqWriteData,
        input  i_reqByteEn,
        input  i_rspReady,
        output o_reqReady,
        output o_rspValid,
        output o_rspReadData,
        output o_rspError
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word-addressed data memory with a fixed response delay.
// A request is accepted in IDLE, optionally held in WAIT for WAIT_CYCLES
// cycles, then committed (store) or sampled (load) on the edge into RESP,
// where the response is held until the initiator takes it.
//
// Ports:
//   i_clk  : clock, all state on rising edge
//   i_srst : synchronous active-high reset (memory contents are kept)
//   bus    : data_mem_responder_if.slave request/response bus
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES : idle cycles between acceptance and response (0..15)
//
// Optional feature macro: DATA_MEM_RESPONDER_ERROR_CHECK_EN
//   defined   : misaligned or out-of-range addresses respond with o_rspError=1,
//               read data 0 and no memory update
//   undefined : o_rspError is 0, low address bits ignored, index wraps
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_srst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LANES   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Architectural state
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    // Captured request
    logic                op_write_q, op_write_d;
    logic [IDX_W-1:0]    op_idx_q, op_idx_d;
    logic [DATA_W-1:0]   op_wdata_q, op_wdata_d;
    logic [LANES-1:0]    op_be_q, op_be_d;
    logic                op_err_q, op_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

    // Decoded request and the operation being committed this cycle
    logic                accept_c;
    logic                req_err_c;
    logic [IDX_W-1:0]    req_idx_c;
    logic                commit_c;
    logic                cur_write_c;
    logic [IDX_W-1:0]    cur_idx_c;
    logic [DATA_W-1:0]   cur_wdata_c;
    logic [LANES-1:0]    cur_be_c;
    logic                cur_err_c;

    assign accept_c  = bus.i_reqValid && req_ready_q;
    assign req_idx_c = bus.i_reqAddress[IDX_W+1:2];

`ifdef DATA_MEM_RESPONDER_ERROR_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    // Reject misaligned words and addresses past the end of the array
    assign req_err_c = (bus.i_reqAddress[1:0] != 2'b00) ||
                       (bus.i_reqAddress >= ADDR_LIMIT);
`else
    logic unused_addr_c;

    assign req_err_c     = 1'b0;
    assign unused_addr_c = ^{bus.i_reqAddress[31:IDX_W+2], bus.i_reqAddress[1:0]};
`endif

    // With WAIT_CYCLES == 0 the commit happens on the acceptance edge, so the
    // live request is used; otherwise the captured copy is.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write_c = bus.i_reqWrite;
            cur_idx_c   = req_idx_c;
            cur_wdata_c = bus.i_reqWriteData;
            cur_be_c    = bus.i_reqByteEn;
            cur_err_c   = req_err_c;
        end else begin
            cur_write_c = op_write_q;
            cur_idx_c   = op_idx_q;
            cur_wdata_c = op_wdata_q;
            cur_be_c    = op_be_q;
            cur_err_c   = op_err_q;
        end
    end

    // Next-state and response logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        op_write_d  = op_write_q;
        op_idx_d    = op_idx_q;
        op_wdata_d  = op_wdata_q;
        op_be_d     = op_be_q;
        op_err_d    = op_err_q;
        commit_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    op_write_d = bus.i_reqWrite;
                    op_idx_d   = req_idx_c;
                    op_wdata_d = bus.i_reqWriteData;
                    op_be_d    = bus.i_reqByteEn;
                    op_err_d   = req_err_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end
            end
            RESP: begin
                if (bus.i_rspReady) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response payload is frozen at the commit edge and held through RESP
        if (commit_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_err_c;
            rsp_data_d  = (cur_write_c || cur_err_c) ? '0 : mem_q[cur_idx_c];
        end
    end

    assign req_ready_d = (state_d == IDLE);

    // Control and response registers
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            op_write_q  <= 1'b0;
            op_idx_q    <= '0;
            op_wdata_q  <= '0;
            op_be_q     <= '0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            op_write_q  <= op_write_d;
            op_idx_q    <= op_idx_d;
            op_wdata_q  <= op_wdata_d;
            op_be_q     <= op_be_d;
            op_err_q    <= op_err_d;
        end
    end

    // Byte-lane store; reset blocks a commit on the same edge, never clears
    always_ff @(posedge i_clk) begin
        if (!i_srst && commit_c && cur_write_c && !cur_err_c) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (cur_be_c[b]) begin
                    mem_q[cur_idx_c][8*b +: 8] <= cur_wdata_c[8*b +: 8];
                end
            end
        end
    end

    assign bus.o_reqReady    = req_ready_q;
    assign bus.o_rspValid    = rsp_valid_q;
    assign bus.o_rspReadData = rsp_data_q;
    assign bus.o_rspError    = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: WAIT_CYCLES=2 instance for the
// main traffic plus a WAIT_CYCLES=0 instance for the zero-wait path.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAITC = 2;
    localparam int unsigned IDXW  = $clog2(DEPTH);
`ifdef DATA_MEM_RESPONDER_ERROR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    data_mem_responder_if bus0();
    data_mem_responder_if bus1();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut0 (
        .i_clk  (clk),
        .i_srst (srst),
        .bus    (bus0)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
        .i_clk  (clk),
        .i_srst (srst),
        .bus    (bus1)
    );

    rsp_t            exp_q[$];
    logic [31:0]     model [DEPTH];
    logic            pend_wr;
    logic [IDXW-1:0] pend_idx;
    logic [31:0]     pend_data;
    logic [3:0]      pend_be;
    int              n_checks = 0;
    int              n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        return ERR_EN && ((a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH)));
    endfunction

    // Present a request on dut0, wait for acceptance, push the expected response
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be);
        int              n;
        logic            e;
        logic [IDXW-1:0] idx;
        rsp_t            r;
        bus0.i_reqValid     = 1'b1;
        bus0.i_reqWrite     = wr;
        bus0.i_reqAddress   = addr;
        bus0.i_reqWriteData = wd;
        bus0.i_reqByteEn    = be;
        n = 0;
        while (bus0.o_reqReady !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready", 32'(bus0.o_reqReady), 32'd1);
        @(posedge clk); #1;
        // Scramble the bus so any late sampling of inputs shows up
        bus0.i_reqValid     = 1'b0;
        bus0.i_reqWrite     = ~wr;
        bus0.i_reqAddress   = 32'h0000_0004 ^ addr;
        bus0.i_reqWriteData = ~wd;
        bus0.i_reqByteEn    = ~be;
        e   = addr_err(addr);
        idx = addr[IDXW+1:2];
        pend_wr   = wr && !e;
        pend_idx  = idx;
        pend_data = wd;
        pend_be   = be;
        r.err  = e;
        r.data = (wr || e) ? 32'd0 : model[idx];
        exp_q.push_back(r);
    endtask

    // Collect a dut0 response, holding it off for 'hold' cycles first
    task automatic recv(input int hold);
        int   lat;
        rsp_t r;
        lat = 1;
        while (bus0.o_rspValid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(WAITC + 1));
        r = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(bus0.o_rspValid), 32'd1);
            check("hold_data", bus0.o_rspReadData, r.data);
            check("hold_req_ready", 32'(bus0.o_reqReady), 32'd0);
            @(posedge clk); #1;
        end
        bus0.i_rspReady = 1'b1;
        check("rsp_data", bus0.o_rspReadData, r.data);
        check("rsp_err", 32'(bus0.o_rspError), 32'(r.err));
        check("done_req_ready", 32'(bus0.o_reqReady), 32'd0);
        @(posedge clk); #1;
        bus0.i_rspReady = 1'b0;
        check("rsp_valid_drop", 32'(bus0.o_rspValid), 32'd0);
        if (pend_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_be[b]) model[pend_idx][8*b +: 8] = pend_data[8*b +: 8];
            end
        end
        pend_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bus0.i_reqValid = 1'b0; bus0.i_reqWrite = 1'b0; bus0.i_reqAddress = '0;
        bus0.i_reqWriteData = '0; bus0.i_reqByteEn = '0; bus0.i_rspReady = 1'b0;
        bus1.i_reqValid = 1'b0; bus1.i_reqWrite = 1'b0; bus1.i_reqAddress = '0;
        bus1.i_reqWriteData = '0; bus1.i_reqByteEn = '0; bus1.i_rspReady = 1'b0;
        pend_wr = 1'b0; pend_idx = '0; pend_data = '0; pend_be = '0;
        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;

        check("rst_rsp_valid", 32'(bus0.o_rspValid), 32'd0);
        check("rst_rsp_data", bus0.o_rspReadData, 32'd0);
        check("rst_rsp_err", 32'(bus0.o_rspError), 32'd0);
        check("rst_req_ready", 32'(bus0.o_reqReady), 32'd1);

        // Full-word store then load back
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF); recv(0);
        send(1'b0, 32'h10, 32'h0, 4'h0);         recv(0);
        // Single-lane merge
        send(1'b1, 32'h10, 32'h0000_00AA, 4'h1); recv(0);
        send(1'b0, 32'h10, 32'h0, 4'h0);         recv(0);
        // Backpressured load held for 5 cycles
        send(1'b0, 32'h10, 32'h0, 4'h0);         recv(5);
        // Zero byte enables: response but no change
        send(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0); recv(1);
        send(1'b0, 32'h10, 32'h0, 4'h0);         recv(0);

        // Fill words 0..7, then random mixed traffic over them
        for (int i = 0; i < 8; i++) begin
            if (i != 4) begin
                send(1'b1, 32'(i * 4), $urandom, 4'hF); recv(0);
            end
        end
        for (int i = 0; i < 24; i++) begin
            a = 32'($urandom_range(0, 7) * 4);
            send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            recv($urandom_range(0, 2));
        end

        // Misaligned and out-of-range stores, then reads of the affected words
        send(1'b1, 32'h12, 32'h1357_9BDF, 4'hF);  recv(0);
        send(1'b1, 32'h400, 32'h2468_ACE0, 4'hF); recv(0);
        send(1'b0, 32'h10, 32'h0, 4'h0);          recv(0);
        send(1'b0, 32'h0, 32'h0, 4'h0);           recv(0);
        send(1'b0, 32'h400, 32'h0, 4'h0);         recv(0);

        // Reset while a load sits in WAIT: no response, ready right after
        send(1'b0, 32'h10, 32'h0, 4'h0);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        void'(exp_q.pop_back());
        pend_wr = 1'b0;
        check("rst_wait_valid", 32'(bus0.o_rspValid), 32'd0);
        check("rst_wait_ready", 32'(bus0.o_reqReady), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rst_wait_quiet", 32'(bus0.o_rspValid), 32'd0);

        // Reset on the commit edge of a store wins: memory unchanged
        send(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        void'(exp_q.pop_back());
        pend_wr = 1'b0;
        check("rst_commit_valid", 32'(bus0.o_rspValid), 32'd0);
        send(1'b0, 32'h10, 32'h0, 4'h0); recv(0);

        // Zero-wait instance: response in the cycle after acceptance
        bus1.i_reqValid = 1'b1; bus1.i_reqWrite = 1'b1; bus1.i_reqAddress = 32'h20;
        bus1.i_reqWriteData = 32'h1234_5678; bus1.i_reqByteEn = 4'hF;
        check("w0_req_ready", 32'(bus1.o_reqReady), 32'd1);
        @(posedge clk); #1;
        bus1.i_reqValid = 1'b0; bus1.i_reqWriteData = 32'h0;
        check("w0_st_valid", 32'(bus1.o_rspValid), 32'd1);
        check("w0_st_data", bus1.o_rspReadData, 32'd0);
        check("w0_st_err", 32'(bus1.o_rspError), 32'd0);
        check("w0_st_ready", 32'(bus1.o_reqReady), 32'd0);
        bus1.i_rspReady = 1'b1;
        @(posedge clk); #1;
        bus1.i_rspReady = 1'b0;
        check("w0_st_drop", 32'(bus1.o_rspValid), 32'd0);
        bus1.i_reqValid = 1'b1; bus1.i_reqWrite = 1'b0;
        @(posedge clk); #1;
        bus1.i_reqValid = 1'b0;
        check("w0_ld_valid", 32'(bus1.o_rspValid), 32'd1);
        check("w0_ld_data", bus1.o_rspReadData, 32'h1234_5678);
        bus1.i_rspReady = 1'b1;
        @(posedge clk); #1;
        bus1.i_rspReady = 1'b0;
        check("w0_ld_drop", 32'(bus1.o_rspValid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
